reg_file_mp: RTL and testbench

//  Parametrised multi-port register file for the decode stage; successor to the 8x16 single-write file.

---
 rtl/reg_file_mp.sv | 119 +++++++++++
 tb/tb_reg_file_mp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write-first bypass, single clear and clear-all sweep
module reg_file_mp #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int N_RD    = 2,
    parameter int R0_ZERO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     clr_one,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic                     clr_all,
    output logic                     busy,
    output logic                     clr_done,
    output logic                     wr_conflict
);

    localparam int               DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    logic [0:0]              r_state;
    logic [ADDR_W-1:0]       r_ptr;
    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [N_RD*DATA_W-1:0]  r_rd_data;
    logic                    r_clr_done;
    logic                    r_wr_conflict;

    logic                    w_busy;
    logic [N_RD*DATA_W-1:0]  w_rd_next;

    assign w_busy      = (r_state == ST_SWEEP);
    assign busy        = w_busy;
    assign rd_data     = r_rd_data;
    assign clr_done    = r_clr_done;
    assign wr_conflict = r_wr_conflict;

    // Value a read port must see after this edge: same-cycle clear/write wins over stored data.
    function automatic logic [DATA_W-1:0] f_rd_value(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (w_busy || ((R0_ZERO != 0) && (a == '0))) begin
            v = '0;
        end else if (clr_one && (clr_addr == a)) begin
            v = '0;
        end else if (we0 && (wa0 == a)) begin
            v = wd0;
        end else if (we1 && (wa1 == a)) begin
            v = wd1;
        end else begin
            v = r_mem[a];
        end
        return v;
    endfunction

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        assign w_a = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_rd_next[k*DATA_W +: DATA_W] = f_rd_value(w_a);
    end

    // Sweep sequencer, registered read data and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_SWEEP;
            r_ptr         <= '0;
            r_rd_data     <= '0;
            r_clr_done    <= 1'b0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_rd_data     <= w_rd_next;
            r_clr_done    <= 1'b0;
            r_wr_conflict <= 1'b0;
            if (w_busy) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_ptr == LAST_PTR) begin
                    r_state    <= ST_IDLE;
                    r_clr_done <= 1'b1;
                end
            end else begin
                r_wr_conflict <= we0 && we1 && (wa0 == wa1);
                if (clr_all) begin
                    r_state <= ST_SWEEP;
                    r_ptr   <= '0;
                end
            end
        end
    end

    // Storage update; later assignments win, giving clr_one > port0 > port1 per entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_busy) begin
                r_mem[r_ptr] <= '0;
            end else begin
                if (we1 && !((R0_ZERO != 0) && (wa1 == '0))) begin
                    r_mem[wa1] <= wd1;
                end
                if (we0 && !((R0_ZERO != 0) && (wa0 == '0))) begin
                    r_mem[wa0] <= wd0;
                end
                if (clr_one && !((R0_ZERO != 0) && (clr_addr == '0))) begin
                    r_mem[clr_addr] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp against a behavioural model
module tb_reg_file_mp;

    logic        clk;
    logic        rst;
    logic [5:0]  rd_addr;
    logic        we0, we1, clr_one, clr_all;
    logic [2:0]  wa0, wa1, clr_addr;
    logic [15:0] wd0, wd1;

    logic [31:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b, done_a, done_b, conf_a, conf_b;

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .N_RD(2), .R0_ZERO(0)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .clr_one(clr_one), .clr_addr(clr_addr), .clr_all(clr_all),
        .busy(busy_a), .clr_done(done_a), .wr_conflict(conf_a)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .N_RD(2), .R0_ZERO(1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .clr_one(clr_one), .clr_addr(clr_addr), .clr_all(clr_all),
        .busy(busy_b), .clr_done(done_b), .wr_conflict(conf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] ma [8];
    logic [15:0] mb [8];
    int          sweep_left;
    logic [31:0] exp_rd_a, exp_rd_b;
    logic        exp_done, exp_conf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int a;
        if (rst) begin
            sweep_left = 8;
            exp_done   = 1'b0;
            exp_conf   = 1'b0;
            exp_rd_a   = '0;
            exp_rd_b   = '0;
        end else if (sweep_left > 0) begin
            ma[8 - sweep_left] = '0;
            mb[8 - sweep_left] = '0;
            sweep_left--;
            exp_done = (sweep_left == 0);
            exp_conf = 1'b0;
            exp_rd_a = '0;
            exp_rd_b = '0;
        end else begin
            exp_done = 1'b0;
            exp_conf = we0 && we1 && (wa0 == wa1);
            if (we1)     begin ma[wa1] = wd1; mb[wa1] = wd1; end
            if (we0)     begin ma[wa0] = wd0; mb[wa0] = wd0; end
            if (clr_one) begin ma[clr_addr] = '0; mb[clr_addr] = '0; end
            for (int k = 0; k < 2; k++) begin
                a = int'(rd_addr[k*3 +: 3]);
                exp_rd_a[k*16 +: 16] = ma[a];
                exp_rd_b[k*16 +: 16] = (a == 0) ? 16'h0 : mb[a];
            end
            if (clr_all) sweep_left = 8;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("busy_a", busy_a, sweep_left > 0);
        check("busy_b", busy_b, sweep_left > 0);
        check("clr_done_a", done_a, exp_done);
        check("clr_done_b", done_b, exp_done);
        check("wr_conflict_a", conf_a, exp_conf);
        check("wr_conflict_b", conf_b, exp_conf);
        check("rd_data_a", rd_data_a, exp_rd_a);
        check("rd_data_b", rd_data_b, exp_rd_b);
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; clr_one = 0; clr_all = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; clr_addr = 0;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 8; i++) begin ma[i] = '0; mb[i] = '0; end
        sweep_left = 8; exp_done = 0; exp_conf = 0; exp_rd_a = 0; exp_rd_b = 0;
        idle_inputs();
        rd_addr = 6'h0;
        rst = 1;

        // reset two cycles, then the power-on sweep
        cycle(); cycle();
        check("reset_rd_a", rd_data_a, 32'h0);
        check("reset_busy", busy_a, 1'b1);
        rst = 0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            rd_addr = 6'($urandom);
            cycle();
            if (busy_a) cnt++;
            if (i == 7) check("poweron_clr_done", done_a, 1'b1);
        end
        check("poweron_busy_after_release", cnt, 7);

        // write-first bypass on port 0
        we0 = 1; wa0 = 3; wd0 = 16'hABCD; rd_addr = {3'd0, 3'd3};
        cycle();
        check("bypass_abcd", rd_data_a[15:0], 16'hABCD);
        idle_inputs();
        cycle();
        check("hold_abcd", rd_data_a[15:0], 16'hABCD);

        // same-address conflict: port 0 wins
        we0 = 1; wa0 = 5; wd0 = 16'h1111; we1 = 1; wa1 = 5; wd1 = 16'h2222; rd_addr = {3'd5, 3'd5};
        cycle();
        check("conflict_flag", conf_a, 1'b1);
        check("conflict_rd", rd_data_a, 32'h1111_1111);
        idle_inputs();
        we1 = 1; wa1 = 6; wd1 = 16'h3333; rd_addr = {3'd6, 3'd5};
        cycle();
        check("conflict_pulse_ends", conf_a, 1'b0);
        check("we1_alone", rd_data_a, 32'h3333_1111);
        idle_inputs();
        cycle();

        // clr_one beats a same-cycle write
        we0 = 1; wa0 = 2; wd0 = 16'h00FF; rd_addr = {3'd2, 3'd2};
        cycle();
        idle_inputs();
        clr_one = 1; clr_addr = 2; we1 = 1; wa1 = 2; wd1 = 16'h7777;
        cycle();
        check("clr_one_same_cycle", rd_data_a[15:0], 16'h0);
        idle_inputs();
        cycle();
        check("clr_one_after", rd_data_a[15:0], 16'h0);

        // fill, clear-all sweep, write during sweep dropped
        for (int i = 0; i < 8; i++) begin
            we0 = 1; wa0 = 3'(i); wd0 = 16'(i + 1); rd_addr = {3'(i), 3'(i)};
            cycle();
        end
        idle_inputs();
        clr_all = 1;
        cycle();
        clr_all = 0;
        cnt = busy_a ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin we0 = 1; wa0 = 4; wd0 = 16'h5A5A; clr_all = 1; end
            else begin we0 = 0; clr_all = 0; end
            rd_addr = 6'($urandom);
            cycle();
            if (busy_a) cnt++;
        end
        check("clr_all_busy_cycles", cnt, 8);
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            rd_addr = {3'(7 - i), 3'(i)};
            cycle();
            check("swept_zero", rd_data_a, 32'h0);
        end

        // hardwired entry 0 and reset mid-sweep
        we0 = 1; wa0 = 0; wd0 = 16'hFFFF; rd_addr = {3'd0, 3'd0};
        cycle();
        check("r0_zero_b", rd_data_b, 32'h0);
        check("r0_normal_a", rd_data_a, 32'hFFFF_FFFF);
        idle_inputs();
        clr_all = 1;
        cycle();
        clr_all = 0;
        cycle(); cycle(); cycle();
        rst = 1;
        cycle();
        rst = 0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (busy_a) cnt++;
        end
        check("rst_mid_sweep_restart", cnt, 7);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            clr_all  = ($urandom_range(0, 39) == 0);
            clr_one  = ($urandom_range(0, 7) == 0);
            we0      = 1'($urandom);
            we1      = 1'($urandom);
            wa0      = 3'($urandom);
            wa1      = ($urandom_range(0, 3) == 0) ? wa0 : 3'($urandom);
            clr_addr = 3'($urandom);
            wd0      = 16'($urandom);
            wd1      = 16'($urandom);
            rd_addr  = 6'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
